// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access stage.
package dmem_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BE_WORD     = 4'b1111;
   localparam int         TIMEOUT_DEF = 16;

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane steering for LDRB/STRB: write byte enables and replicated
// store data on the request side, zero-extended byte pick on the load side.
module dmem_byte_lane
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              i_byte_wr,
   input  logic [1:0]        i_off_wr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [3:0]        o_be,
   output logic [DATA_W-1:0] o_wdata,
   input  logic              i_byte_rd,
   input  logic [1:0]        i_off_rd,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_rdata
);

   // Request side: one-hot enable and the byte copied into every lane.
   always_comb begin
      o_be    = BE_WORD;
      o_wdata = i_wdata;
      if (i_byte_wr) begin
         o_be    = 4'b0001 << i_off_wr;
         o_wdata = {4{i_wdata[7:0]}};
      end
   end

   // Load side: pick the addressed byte and zero-extend it.
   always_comb begin
      o_rdata = i_rdata;
      if (i_byte_rd)
         o_rdata = {{(DATA_W-8){1'b0}}, i_rdata[{i_off_rd, 3'b000} +: 8]};
   end

endmodule

// File: rtl/dmem_interface.sv
// Data-memory access stage: turns MemRead/MemWrite into a req/ack bus
// transaction and stalls the core until it completes, faults or times out.
// Optional byte accesses (LDRB/STRB) are built when DMEM_BYTE_EN is defined.
module dmem_interface
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              ByteAccess,
   input  logic [ADDR_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] WriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              Stall,
   output logic              Fault,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT);

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_req, w_byte, w_misal, w_bad, w_tmo;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata, w_rdata;

   assign w_req   = MemRead | MemWrite;
   assign w_misal = ~w_byte & (ALUResult[1:0] != 2'b00);
   assign w_bad   = (MemRead & MemWrite) | w_misal;
   assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef DMEM_BYTE_EN
   logic       r_byte;
   logic [1:0] r_off;

   assign w_byte = ByteAccess;

   dmem_byte_lane #(.DATA_W(DATA_W)) u_lane (
      .i_byte_wr (w_byte),
      .i_off_wr  (ALUResult[1:0]),
      .i_wdata   (WriteData),
      .o_be      (w_be),
      .o_wdata   (w_wdata),
      .i_byte_rd (r_byte),
      .i_off_rd  (r_off),
      .i_rdata   (bus_rdata),
      .o_rdata   (w_rdata)
   );

   // Remember the byte selection so the load side can extract after ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_byte <= 1'b0;
         r_off  <= 2'b00;
      end else if (r_state == S_IDLE && w_req) begin
         r_byte <= w_byte;
         r_off  <= ALUResult[1:0];
      end
   end
`else
   logic w_unused_byte;

   assign w_unused_byte = ByteAccess;
   assign w_byte  = 1'b0;
   assign w_be    = BE_WORD;
   assign w_wdata = WriteData;
   assign w_rdata = bus_rdata;
`endif

   // Next state and stall; stall is combinational so the core freezes in
   // the same cycle the request appears.
   always_comb begin
      w_next = r_state;
      Stall  = 1'b0;
      case (r_state)
         S_IDLE: if (w_req) begin
            Stall  = 1'b1;
            w_next = w_bad ? S_DONE : S_BUS;
         end
         S_BUS: begin
            Stall = 1'b1;
            if (bus_ack || w_tmo)
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (reset)
         Stall = 1'b0;
   end

   // State register, bus request registers, timeout counter and results.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         ReadData  <= '0;
         Fault     <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= 4'b0000;
      end else begin
         r_state <= w_next;
         Fault   <= 1'b0;
         case (r_state)
            S_IDLE: if (w_req) begin
               if (w_bad) begin
                  Fault <= 1'b1;
                  if (MemRead)
                     ReadData <= '0;
               end else begin
                  bus_req   <= 1'b1;
                  bus_we    <= MemWrite;
                  bus_addr  <= {ALUResult[ADDR_W-1:2], 2'b00};
                  bus_wdata <= w_wdata;
                  bus_be    <= w_be;
                  r_cnt     <= '0;
               end
            end
            S_BUS: begin
               // Ack beats a timeout that expires in the same cycle.
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (!bus_we)
                     ReadData <= w_rdata;
               end else if (w_tmo) begin
                  bus_req <= 1'b0;
                  Fault   <= 1'b1;
                  if (!bus_we)
                     ReadData <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_interface.sv
// Self-checking bench for dmem_interface: directed table, reset corner
// cases and randomized transactions against a transaction-level model.
// Byte-access vectors are added when DMEM_BYTE_EN is defined.
module tb_dmem_interface;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite, ByteAccess;
   logic [31:0] ALUResult, WriteData;
   logic [31:0] ReadData;
   logic        Stall, Fault;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   dmem_interface #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .MemRead(MemRead), .MemWrite(MemWrite), .ByteAccess(ByteAccess),
      .ALUResult(ALUResult), .WriteData(WriteData),
      .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit          wr;
      bit          bt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_k;   // bus_req cycle that sees ack; out of 1..TO = never
      bit          ef;
      int          ereq;
      logic [31:0] erd;
   } vec_t;

   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] model_rd = '0;
   vec_t        tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(bit rd, bit wr, bit bt, logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] rdata, int ack_k, bit ef, int ereq, logic [31:0] erd);
      vec_t v;
      v.rd = rd; v.wr = wr; v.bt = bt; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.ack_k = ack_k; v.ef = ef; v.ereq = ereq; v.erd = erd;
      return v;
   endfunction

   function automatic bit is_byte(vec_t v);
`ifdef DMEM_BYTE_EN
      return v.bt;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] exp_be(vec_t v);
      if (is_byte(v)) return 4'(1 << v.addr[1:0]);
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(vec_t v);
      logic [7:0] b;
      b = v.wdata[7:0];
      if (is_byte(v)) return {b, b, b, b};
      return v.wdata;
   endfunction

   // Transaction-level reference: outcome of one memory instruction.
   function automatic void model(inout vec_t v, input logic [31:0] prev);
      bit byt;
      byt = is_byte(v);
      if ((v.rd && v.wr) || (!byt && v.addr[1:0] != 2'b00)) begin
         v.ef = 1; v.ereq = 0; v.erd = v.rd ? 32'h0 : prev;
      end else if (v.ack_k >= 1 && v.ack_k <= TO) begin
         v.ef = 0; v.ereq = v.ack_k;
         if (!v.rd)    v.erd = prev;
         else if (byt) v.erd = (v.rdata >> (8 * int'(v.addr[1:0]))) & 32'hFF;
         else          v.erd = v.rdata;
      end else begin
         v.ef = 1; v.ereq = TO; v.erd = v.rd ? 32'h0 : prev;
      end
   endfunction

   // Drive one instruction starting just after a clock edge in S_IDLE and
   // act as the bus slave; ends just after the edge that returns to S_IDLE.
   task automatic apply(input vec_t v, input string tag);
      int          req_cyc, done_cyc, fcnt;
      logic        stall0, fo;
      logic [31:0] rdo;
      req_cyc = 0; done_cyc = -1; fcnt = 0; stall0 = 1'b0; fo = 1'b0; rdo = '0;
      MemRead = v.rd; MemWrite = v.wr; ByteAccess = v.bt;
      ALUResult = v.addr; WriteData = v.wdata;
      for (int c = 0; c < TO + 6 && done_cyc < 0; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         bus_ack = 1'b0;
         if (bus_req) begin
            req_cyc++;
            chk({tag, " bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
            chk({tag, " bus_we"}, {31'b0, bus_we}, {31'b0, v.wr});
            chk({tag, " bus_be"}, {28'b0, bus_be}, {28'b0, exp_be(v)});
            chk({tag, " bus_wdata"}, bus_wdata, exp_wdata(v));
            if (req_cyc == v.ack_k) begin
               bus_ack = 1'b1;
               bus_rdata = v.rdata;
            end
         end
         @(negedge clk);
         if (Fault) fcnt++;
         if (c == 0) stall0 = Stall;
         else if (!Stall) begin
            done_cyc = c; fo = Fault; rdo = ReadData;
         end
      end
      bus_ack = 1'b0;
      chk({tag, " stall_first"}, {31'b0, stall0}, 32'd1);
      chk({tag, " req_cycles"}, 32'(req_cyc), 32'(v.ereq));
      chk({tag, " done_cycle"}, 32'(done_cyc), 32'(v.ereq + 1));
      chk({tag, " fault"}, {31'b0, fo}, {31'b0, v.ef});
      chk({tag, " fault_cycles"}, 32'(fcnt), 32'(v.ef));
      chk({tag, " rdata"}, rdo, v.erd);
      model_rd = v.erd;
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0; ByteAccess = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " bus_req"}, {31'b0, bus_req}, 32'd0);
      chk({tag, " Stall"}, {31'b0, Stall}, 32'd0);
      chk({tag, " Fault"}, {31'b0, Fault}, 32'd0);
      chk({tag, " ReadData"}, ReadData, 32'd0);
      chk({tag, " bus_we"}, {31'b0, bus_we}, 32'd0);
      chk({tag, " bus_addr"}, bus_addr, 32'd0);
      chk({tag, " bus_wdata"}, bus_wdata, 32'd0);
      chk({tag, " bus_be"}, {28'b0, bus_be}, 32'd0);
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; ByteAccess = 1'b0;
      ALUResult = 32'h100; WriteData = '0; bus_ack = 1'b0; bus_rdata = '0;
      #3;
      chk_all_zero("reset");
      MemRead = 1'b0;
      #9 reset = 1'b0;
      @(posedge clk); #1;

      // Directed table: expected values written from the block's rules.
      tbl.push_back(mk(1,0,0,32'h100,32'h0,32'hDEADBEEF, 2,0, 2,32'hDEADBEEF));
      tbl.push_back(mk(0,1,0,32'h204,32'h12345678,32'h0, 1,0, 1,32'hDEADBEEF));
      tbl.push_back(mk(1,0,0,32'h102,32'h0,32'h0,        1,1, 0,32'h0));
      tbl.push_back(mk(1,0,0,32'h104,32'h0,32'hCAFEF00D, 3,0, 3,32'hCAFEF00D));
      tbl.push_back(mk(1,0,0,32'h100,32'h0,32'h0,        0,1,TO,32'h0));
      tbl.push_back(mk(1,0,0,32'h108,32'h0,32'h55AA55AA,TO,0,TO,32'h55AA55AA));
      tbl.push_back(mk(1,1,0,32'h010,32'h0,32'h0,        1,1, 0,32'h0));
      tbl.push_back(mk(1,0,0,32'h10C,32'h0,32'h0BADF00D, 1,0, 1,32'h0BADF00D));
      tbl.push_back(mk(0,1,0,32'h206,32'h11111111,32'h0, 1,1, 0,32'h0BADF00D));
`ifdef DMEM_BYTE_EN
      tbl.push_back(mk(0,1,1,32'h203,32'h000000AB,32'h0, 1,0, 1,32'h0BADF00D));
      tbl.push_back(mk(1,0,1,32'h201,32'h0,32'h11223344, 1,0, 1,32'h00000033));
`endif
      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("tbl%0d", i));

      // bus_ack while idle must not disturb anything.
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("idle_ack Stall", {31'b0, Stall}, 32'd0);
         chk("idle_ack Fault", {31'b0, Fault}, 32'd0);
         chk("idle_ack bus_req", {31'b0, bus_req}, 32'd0);
         chk("idle_ack ReadData", ReadData, model_rd);
         @(posedge clk); #1;
      end
      bus_ack = 1'b0;

      // Reset while the bus transaction is outstanding.
      MemRead = 1'b1; ALUResult = 32'h100;
      @(posedge clk); #1;
      chk("midrst bus_req_before", {31'b0, bus_req}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk_all_zero("midrst");
      MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_rd = '0;
      @(posedge clk); #1;
      apply(mk(1,0,0,32'h100,32'h0,32'h600DF00D,2,0,2,32'h600DF00D), "post_rst");

      // Randomized instructions against the transaction model.
      for (int i = 0; i < 40; i++) begin
         int r;
         r = int'($urandom_range(0, 15));
         v.rd = (r == 0) || (r < 9);
         v.wr = (r == 0) || (r >= 9);
`ifdef DMEM_BYTE_EN
         v.bt = 1'($urandom_range(0, 1));
`else
         v.bt = 1'b0;
`endif
         v.addr = $urandom;
         if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
         v.wdata = $urandom;
         v.rdata = $urandom;
         v.ack_k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2))
                                               : int'($urandom_range(1, 4));
         model(v, model_rd);
         apply(v, $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/dmem_interface.md
Name: dmem_interface

Overview:
- Data-memory access stage directly downstream of the single-cycle ARM datapath.
- Consumes the datapath's address (ALUResult), store data (WriteData) and the controller's MemRead/MemWrite.
- Runs a req/ack transaction on an external memory bus and returns ReadData to the result mux.
- Holds the core with Stall until the transaction completes, faults or times out.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width (fixed to 32 in this core).
- TIMEOUT, 16, maximum bus_req cycles without bus_ack before the access is aborted (TIMEOUT >= 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load request from controller.
- MemWrite  in  1  store request from controller.
- ByteAccess  in  1  LDRB/STRB select; ignored unless DMEM_BYTE_EN.
- ALUResult  in  ADDR_W  access address.
- WriteData  in  DATA_W  store data.
- ReadData  out  DATA_W  registered load result.
- Stall  out  1  freezes PC/regfile write while high.
- Fault  out  1  one-cycle pulse: misaligned, illegal or timed-out access.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  transaction complete; bus_rdata valid in the same cycle.
- bus_rdata  in  DATA_W  bus read data.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state S_IDLE; ReadData, Fault, bus_req, bus_we, bus_addr, bus_wdata, bus_be all 0; Stall forced 0 while reset is high.
- Reset mid-transaction: bus_req drops immediately (asynchronously) and no completion is reported.
- FSM states: S_IDLE, S_BUS, S_DONE.
- S_IDLE, no request: outputs hold, Stall=0.
- S_IDLE, request = MemRead|MemWrite: Stall=1 combinationally in the same cycle.
  - Legal request: latch address, data, we and be into the bus_* registers; set bus_req=1; go to S_BUS.
  - Misaligned word access (ALUResult[1:0] != 0): no bus transaction; go to S_DONE with fault set.
  - MemRead and MemWrite both high: no bus transaction; go to S_DONE with fault set.
- S_BUS: Stall=1; bus_addr, bus_we, bus_wdata and bus_be are held stable until bus_req falls.
  - On bus_ack: bus_req=0; for reads, ReadData <= bus_rdata; go to S_DONE.
  - Timeout counter counts bus_req cycles. If TIMEOUT cycles pass with no ack: bus_req=0, ReadData <= 0, go to S_DONE with fault.
  - bus_ack and timeout in the same cycle: ack wins, no fault.
- S_DONE: Stall=0 for exactly one cycle, so the instruction retires and PC advances. Fault=1 this cycle if a fault was recorded. Next state is S_IDLE.
- Faulted load: ReadData=0. Writes leave ReadData unchanged.
- Latency: request seen in cycle N; bus_req rises in N+1; ack in cycle N+k (k>=1) gives S_DONE, Stall=0 and valid ReadData in N+k+1. Minimum is 3 cycles per memory instruction.
- bus_ack outside S_BUS is ignored.
- Word access: bus_be=4'b1111; bus_addr = {ALUResult[ADDR_W-1:2], 2'b00}; bus_wdata = WriteData.

Optional Feature:
- Macro: DMEM_BYTE_EN.
- Defined: ByteAccess=1 selects byte accesses.
  - bus_be = one-hot of ALUResult[1:0].
  - bus_wdata = WriteData[7:0] replicated 4 times.
  - ReadData = zero-extended byte selected by ALUResult[1:0].
  - No misalignment fault for byte accesses.
- Undefined: ByteAccess is ignored; all accesses are word accesses; the port remains, so the interface is stable.

Decomposition:
- Package dmem_pkg: state enum {S_IDLE, S_BUS, S_DONE}; BE_WORD = 4'b1111; TIMEOUT default constant.
- One sub-module, dmem_byte_lane: write-lane steering (be/wdata) and read-byte extraction. Instantiated only under DMEM_BYTE_EN.

Test Plan:
- Word read 0x100, ack on the 2nd bus_req cycle with rdata 0xDEADBEEF -> Stall high cycles 0-2; bus_req high cycles 1-2; cycle 3 Stall=0, ReadData=0xDEADBEEF, Fault=0.
- Word write 0x204 / 0x12345678, ack immediately -> bus_we=1, bus_be=1111, bus_wdata=0x12345678; Stall=0 in cycle 2.
- Word read 0x102 (misaligned) -> no bus_req; cycle 1 Fault=1, Stall=0, ReadData=0.
- Read with bus_ack tied 0, TIMEOUT=16 -> bus_req high exactly 16 cycles, then Fault pulse and ReadData=0; ack arriving in the 16th cycle -> no fault.
- reset asserted in S_BUS -> bus_req=0 immediately, all outputs 0; after release, a read of 0x100 completes normally.
- DMEM_BYTE_EN: STRB 0x203 / 0xAB -> bus_be=1000, bus_wdata=0xABABABAB; LDRB 0x201 with rdata 0x11223344 -> ReadData=0x00000033.
